id_decode: RTL and testbench
============================

# id_decode

Instruction decode stage for the 8-bit SimpleCPU. It accepts instruction bytes from fetch over a valid/ready handshake and assembles two-byte LOADIMM instructions. It translates each instruction into the 4-bit mode code, register indices, immediate and control strobes that the execute-stage ALU consumes. It is the producing end of the ALU mode interface, and its output register feeds EXE directly.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard partial and pending instruction (branch/redirect)
- in_byte  in  8  instruction byte from fetch
- in_valid  in  1  in_byte is valid
- in_ready  out  1  decoder accepts in_byte this cycle
- out_valid  out  1  decoded instruction held in output register
- out_ready  in  1  EXE consumes the output this cycle
- dec_mode  out  4  ALU mode code
- dec_rs1  out  2  source register 1 index
- dec_rs2  out  2  source register 2 index
- dec_rd  out  2  destination register index
- dec_imm  out  8  immediate (LOADIMM only; else 0)
- dec_reg_we  out  1  write dec_rd with the ALU result
- dec_mem_we  out  1  memory store
- dec_out_en  out  1  drive external output
- dec_in_en  out  1  sample external input
- dec_illegal  out  1  undefined opcode
- instr_count  out  CNT_W  count of instructions handed to EXE

## Operation
- Encoding: byte[7:4] = opcode, [3:2] = ra, [1:0] = rb. For every decoded opcode, dec_mode equals the opcode.
- Opcode 1 ADD, 2 SUB, 3 NAND: rs1=ra, rs2=rb, rd=ra, reg_we=1.
- Opcode 4 SHL, 5 SHR: rs1=ra, rd=ra, rs2=0, reg_we=1.
- Opcode 6 OUT: rs1=ra, out_en=1.
- Opcode 7 IN: rd=ra, in_en=1, reg_we=1.
- Opcode E STORE: rs1=ra (data), rs2=rb (address), mem_we=1.
- Opcode F LOADIMM: two bytes. The first byte carries rd=ra. The next accepted byte is the immediate, taken verbatim (any value, including 0xF?). Output has reg_we=1.
- Opcode 0 NOP: mode 0, all strobes 0.
- Opcodes 8–D: mode 0, all strobes 0, illegal=1. The instruction is still emitted and counted.
- Unused index fields and dec_imm are 0.
- FSM states:
  - S_OP: expect an opcode byte. Accepting F goes to S_IMM and latches ra; no output is produced. Any other opcode produces output and stays in S_OP.
  - S_IMM: expect the immediate. Accepting it produces the LOADIMM output and returns to S_OP.
- in_ready = !out_valid || out_ready, in both states. The S_OP→S_IMM transition needs no output slot, but is gated identically for simplicity.
- Output register: loaded on an accept that completes an instruction. out_valid clears when out_ready && !load. It holds all dec_* values stable while out_valid && !out_ready.
- instr_count increments by 1 on each out_valid && out_ready, and wraps modulo 2^CNT_W.
- flush (synchronous, highest priority):
  - State returns to S_OP, out_valid clears, and the latched ra is discarded.
  - in_ready is forced to 0 that cycle, so no byte is accepted.
  - instr_count is unaffected, except that a same-cycle out_valid && out_ready handshake still counts.

## Timing
- Reset values: state S_OP, out_valid 0, all dec_* 0, instr_count 0. in_ready is 1 during and after reset.
- Single-byte latency: byte accepted at edge N, out_valid and fields visible after edge N, and stable for EXE's negedge sample.
- LOADIMM: output appears after the edge accepting byte 2. No bubble is inserted beyond byte arrival.
- Throughput: 1 instruction/cycle with out_ready held high. A simultaneous drain and load replaces the output in the same edge.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and the fetch byte is held, in either state.
- Reset mid-LOADIMM: the partial instruction is lost and the next byte is decoded as an opcode.
- in_valid with in_ready=0 has no effect.

## Test plan
- Reset then stream 0x16, 0x2B, 0x3E with out_ready=1 → three outputs on consecutive cycles:
  - 0x16: mode 1, rs1=1, rs2=2, rd=1, reg_we=1.
  - 0x2B: mode 2, rs1=2, rs2=3, rd=2, reg_we=1.
  - 0x3E: mode 3, rs1=3, rs2=2, rd=3, reg_we=1.
  - instr_count=3.
- LOADIMM: 0xF8 then 0xF0 → one output only, after the second byte: mode F, rd=2, imm=0xF0, reg_we=1. No output after the first byte.
- Backpressure: hold out_ready=0 after 0x61 → in_ready=0, and mode 6, rs1=0, out_en=1 is held for 5 cycles. Raise out_ready with 0x73 waiting → next cycle shows mode 7, rd=0, in_en=1.
- Flush during S_IMM after 0xF4, then 0x1B → output mode 1, rs1=2, rs2=3, rd=2. No LOADIMM is emitted and count is unchanged by the flush.
- Illegal 0x9C and STORE 0xE6 → 0x9C gives mode 0, illegal=1, no strobes. 0xE6 gives mode E, rs1=1, rs2=2, mem_we=1, reg_we=0.
- Async rst asserted mid-stream → all outputs 0 immediately. Counter wrap: preload via 2^CNT_W handshakes (CNT_W=4) → 16 instructions give instr_count=0.

Source files
------------

// File: rtl/id_decode.sv
// id_decode: SimpleCPU decode stage. Accepts instruction bytes from fetch,
// assembles two-byte LOADIMM instructions and holds each decoded instruction
// in an output register that feeds the execute stage directly.
module id_decode #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       dec_mode,
  output logic [1:0]       dec_rs1,
  output logic [1:0]       dec_rs2,
  output logic [1:0]       dec_rd,
  output logic [7:0]       dec_imm,
  output logic             dec_reg_we,
  output logic             dec_mem_we,
  output logic             dec_out_en,
  output logic             dec_in_en,
  output logic             dec_illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ra_q, ra_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] mode_q, mode_d;
  logic [1:0] rs1_q, rs1_d;
  logic [1:0] rs2_q, rs2_d;
  logic [1:0] rd_q, rd_d;
  logic [7:0] imm_q, imm_d;
  logic       reg_we_q, reg_we_d;
  logic       mem_we_q, mem_we_d;
  logic       out_en_q, out_en_d;
  logic       in_en_q, in_en_d;
  logic       illegal_q, illegal_d;

  logic       accept;
  logic       load;
  logic [3:0] opc;
  logic [1:0] fa, fb;

  assign opc = in_byte[7:4];
  assign fa  = in_byte[3:2];
  assign fb  = in_byte[1:0];

  // Flush blocks acceptance; otherwise accept whenever the output slot is free or draining.
  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state, instruction decode and output-register load selection.
  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    load      = 1'b0;
    mode_d    = mode_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    reg_we_d  = reg_we_q;
    mem_we_d  = mem_we_q;
    out_en_d  = out_en_q;
    in_en_d   = in_en_q;
    illegal_d = illegal_q;

    if (accept) begin
      if (state_q == S_IMM) begin
        load      = 1'b1;
        state_d   = S_OP;
        mode_d    = 4'hF;
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = ra_q;
        imm_d     = in_byte;
        reg_we_d  = 1'b1;
        mem_we_d  = 1'b0;
        out_en_d  = 1'b0;
        in_en_d   = 1'b0;
        illegal_d = 1'b0;
      end else if (opc == 4'hF) begin
        state_d = S_IMM;
        ra_d    = fa;
      end else begin
        load      = 1'b1;
        mode_d    = opc;
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = '0;
        imm_d     = '0;
        reg_we_d  = 1'b0;
        mem_we_d  = 1'b0;
        out_en_d  = 1'b0;
        in_en_d   = 1'b0;
        illegal_d = 1'b0;
        unique case (opc)
          4'h1, 4'h2, 4'h3: begin
            rs1_d    = fa;
            rs2_d    = fb;
            rd_d     = fa;
            reg_we_d = 1'b1;
          end
          4'h4, 4'h5: begin
            rs1_d    = fa;
            rd_d     = fa;
            reg_we_d = 1'b1;
          end
          4'h6: begin
            rs1_d    = fa;
            out_en_d = 1'b1;
          end
          4'h7: begin
            rd_d     = fa;
            in_en_d  = 1'b1;
            reg_we_d = 1'b1;
          end
          4'hE: begin
            rs1_d    = fa;
            rs2_d    = fb;
            mem_we_d = 1'b1;
          end
          4'h0: ;
          default: begin
            mode_d    = '0;
            illegal_d = 1'b1;
          end
        endcase
      end
    end

    if (flush) begin
      state_d = S_OP;
      ra_d    = '0;
    end
  end

  // Output-valid and retired-instruction counter bookkeeping.
  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (load)      valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    cnt_d = cnt_q;
    if (valid_q && out_ready) cnt_d = cnt_q + 1'b1;
  end

  // State, pending LOADIMM register index, valid flag and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OP;
      ra_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decoded-instruction output register; holds while EXE stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      reg_we_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      out_en_q  <= 1'b0;
      in_en_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load && !flush) begin
      mode_q    <= mode_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      reg_we_q  <= reg_we_d;
      mem_we_q  <= mem_we_d;
      out_en_q  <= out_en_d;
      in_en_q   <= in_en_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = valid_q;
  assign dec_mode    = mode_q;
  assign dec_rs1     = rs1_q;
  assign dec_rs2     = rs2_q;
  assign dec_rd      = rd_q;
  assign dec_imm     = imm_q;
  assign dec_reg_we  = reg_we_q;
  assign dec_mem_we  = mem_we_q;
  assign dec_out_en  = out_en_q;
  assign dec_in_en   = in_en_q;
  assign dec_illegal = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_id_decode.sv
// Directed testbench for id_decode with hand-computed expectations.
module tb_id_decode;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    dec_mode;
  logic [1:0]    dec_rs1, dec_rs2, dec_rd;
  logic [7:0]    dec_imm;
  logic          dec_reg_we, dec_mem_we, dec_out_en, dec_in_en, dec_illegal;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;

  id_decode #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .dec_mode(dec_mode), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_imm(dec_imm), .dec_reg_we(dec_reg_we), .dec_mem_we(dec_mem_we),
    .dec_out_en(dec_out_en), .dec_in_en(dec_in_en), .dec_illegal(dec_illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic idle;
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_byte = '0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_ready", {31'b0, in_ready}, 1);
    chk("rst_mode",  {28'b0, dec_mode}, 0);
    chk("rst_cnt",   {28'b0, instr_count}, 0);
    rst = 1'b0;
    tick();

    // Back-to-back stream
    feed(8'h16);
    chk("add_valid", {31'b0, out_valid}, 1);
    chk("add_mode", {28'b0, dec_mode}, 1);
    chk("add_rs1", {30'b0, dec_rs1}, 1);
    chk("add_rs2", {30'b0, dec_rs2}, 2);
    chk("add_rd", {30'b0, dec_rd}, 1);
    chk("add_we", {31'b0, dec_reg_we}, 1);
    feed(8'h2B);
    chk("sub_mode", {28'b0, dec_mode}, 2);
    chk("sub_rs1", {30'b0, dec_rs1}, 2);
    chk("sub_rs2", {30'b0, dec_rs2}, 3);
    chk("sub_rd", {30'b0, dec_rd}, 2);
    chk("sub_cnt", {28'b0, instr_count}, 1);
    feed(8'h3E);
    chk("nand_valid", {31'b0, out_valid}, 1);
    chk("nand_mode", {28'b0, dec_mode}, 3);
    chk("nand_rs1", {30'b0, dec_rs1}, 3);
    chk("nand_rs2", {30'b0, dec_rs2}, 2);
    chk("nand_rd", {30'b0, dec_rd}, 3);
    chk("nand_we", {31'b0, dec_reg_we}, 1);
    idle();
    chk("stream_cnt", {28'b0, instr_count}, 3);
    chk("stream_drain", {31'b0, out_valid}, 0);

    // LOADIMM with 0xF? immediate
    feed(8'hF8);
    chk("li_first_noout", {31'b0, out_valid}, 0);
    feed(8'hF0);
    chk("li_valid", {31'b0, out_valid}, 1);
    chk("li_mode", {28'b0, dec_mode}, 4'hF);
    chk("li_rd", {30'b0, dec_rd}, 2);
    chk("li_imm", {24'b0, dec_imm}, 8'hF0);
    chk("li_we", {31'b0, dec_reg_we}, 1);
    idle();
    chk("li_cnt", {28'b0, instr_count}, 4);

    // Backpressure
    out_ready = 1'b0;
    feed(8'h61);
    chk("out_valid", {31'b0, out_valid}, 1);
    in_byte = 8'h73;
    #1;
    chk("bp_ready", {31'b0, in_ready}, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_mode", {28'b0, dec_mode}, 6);
      chk("bp_rs1", {30'b0, dec_rs1}, 0);
      chk("bp_outen", {31'b0, dec_out_en}, 1);
      chk("bp_ready_hold", {31'b0, in_ready}, 0);
    end
    chk("bp_cnt", {28'b0, instr_count}, 4);
    out_ready = 1'b1;
    tick();
    chk("in_mode", {28'b0, dec_mode}, 7);
    chk("in_rd", {30'b0, dec_rd}, 0);
    chk("in_en", {31'b0, dec_in_en}, 1);
    chk("in_outen", {31'b0, dec_out_en}, 0);
    chk("in_cnt", {28'b0, instr_count}, 5);
    idle();
    chk("in_drain_cnt", {28'b0, instr_count}, 6);

    // Flush during S_IMM
    feed(8'hF4);
    flush = 1'b1;
    in_byte = 8'h1B;
    #1;
    chk("flush_ready", {31'b0, in_ready}, 0);
    tick();
    chk("flush_valid", {31'b0, out_valid}, 0);
    chk("flush_cnt", {28'b0, instr_count}, 6);
    flush = 1'b0;
    tick();
    chk("postflush_mode", {28'b0, dec_mode}, 1);
    chk("postflush_rs1", {30'b0, dec_rs1}, 2);
    chk("postflush_rs2", {30'b0, dec_rs2}, 3);
    chk("postflush_rd", {30'b0, dec_rd}, 2);
    chk("postflush_imm", {24'b0, dec_imm}, 0);
    idle();
    chk("postflush_cnt", {28'b0, instr_count}, 7);

    // Illegal and STORE
    feed(8'h9C);
    chk("ill_valid", {31'b0, out_valid}, 1);
    chk("ill_mode", {28'b0, dec_mode}, 0);
    chk("ill_flag", {31'b0, dec_illegal}, 1);
    chk("ill_we", {31'b0, dec_reg_we}, 0);
    chk("ill_rs1", {30'b0, dec_rs1}, 0);
    feed(8'hE6);
    chk("st_mode", {28'b0, dec_mode}, 4'hE);
    chk("st_rs1", {30'b0, dec_rs1}, 1);
    chk("st_rs2", {30'b0, dec_rs2}, 2);
    chk("st_memwe", {31'b0, dec_mem_we}, 1);
    chk("st_regwe", {31'b0, dec_reg_we}, 0);
    chk("st_ill", {31'b0, dec_illegal}, 0);
    chk("st_cnt", {28'b0, instr_count}, 8);
    idle();
    chk("st_drain_cnt", {28'b0, instr_count}, 9);

    // Async reset mid-LOADIMM
    feed(8'h16);
    feed(8'hF5);
    chk("pre_rst_cnt", {28'b0, instr_count}, 10);
    chk("pre_rst_mode", {28'b0, dec_mode}, 1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mode", {28'b0, dec_mode}, 0);
    chk("arst_cnt", {28'b0, instr_count}, 0);
    chk("arst_we", {31'b0, dec_reg_we}, 0);
    chk("arst_rd", {30'b0, dec_rd}, 0);
    chk("arst_ready", {31'b0, in_ready}, 1);
    #3;
    rst = 1'b0;
    tick();
    feed(8'h2B);
    chk("post_rst_valid", {31'b0, out_valid}, 1);
    chk("post_rst_mode", {28'b0, dec_mode}, 2);
    chk("post_rst_imm", {24'b0, dec_imm}, 0);
    idle();
    chk("post_rst_cnt", {28'b0, instr_count}, 1);

    // Counter wrap: fresh reset, then 16 handshakes
    #2;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) feed(8'h00);
    chk("wrap_pre_cnt", {28'b0, instr_count}, 15);
    chk("nop_mode", {28'b0, dec_mode}, 0);
    chk("nop_ill", {31'b0, dec_illegal}, 0);
    chk("nop_we", {31'b0, dec_reg_we}, 0);
    idle();
    chk("wrap_cnt", {28'b0, instr_count}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
